param_fetch_ctrl: RTL and testbench

- Read-side initiator for the synchronous parameter ROM. Given a base address and word count, it issues sequential ROM addresses and absorbs the ROM's 1-cycle read latency.
- Delivers the words as a valid/ready stream (with last flag) to the compute datapath.
- Sits between the weight/bias ROMs and the layer engines. Keeps full 1-word/cycle throughput under backpressure with no data loss.

---
 rtl/param_fetch_ctrl.sv | 148 ++++++++++++++
 tb/tb_param_fetch_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_fetch_ctrl.sv
// param_fetch_ctrl: read-side initiator for a synchronous parameter ROM.
// Issues sequential ROM addresses for a burst and hides the ROM's one-cycle
// read latency. Words are delivered as a valid/ready stream with a last flag.
// A two-entry skid FIFO plus a credit check keeps one word per cycle under
// arbitrary backpressure without dropping any ROM data.
//
// Handshake: a beat transfers on a rising edge where m_valid && m_ready.
// While m_valid=1 and m_ready=0, m_data and m_last hold steady. m_valid
// never drops until its beat has transferred.
module param_fetch_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [ADDR_WIDTH:0]          length,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_WIDTH-1:0]        rom_addr,
  input  logic signed [DATA_WIDTH-1:0] rom_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [DATA_WIDTH-1:0] m_data,
  output logic                         m_last,
  output logic [1:0]                   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   rom_addr_q;
  logic [ADDR_WIDTH:0]     remaining_q;
  logic                    inflight_q;
  logic                    inflight_last_q;
  logic                    busy_q;
  logic                    done_q;

  logic signed [DATA_WIDTH-1:0] buf_data_q [2];
  logic                         buf_last_q [2];
  logic                         wr_ptr_q;
  logic                         rd_ptr_q;
  logic [1:0]                   count_q;

  logic       pop;
  logic       issue;
  logic       final_pop;
  logic [2:0] occupancy;
  logic [2:0] limit;

  // Credit check: an issue is allowed only if the word it will produce next
  // cycle is guaranteed a FIFO slot, counting the word already in flight.
  always_comb begin
    pop       = (count_q != 2'd0) && m_ready;
    occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    limit     = 3'd2 + {2'b00, pop};
    issue     = (state_q == S_FETCH) && (remaining_q != '0) && (occupancy < limit);
    final_pop = pop && buf_last_q[rd_ptr_q];
  end

  // Burst FSM: address issue, remaining count, busy/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      rom_addr_q      <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      inflight_q      <= issue;
      inflight_last_q <= issue && (remaining_q == REM_ONE);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (length != '0) begin
              state_q     <= S_FETCH;
              busy_q      <= 1'b1;
              rom_addr_q  <= base_addr;
              remaining_q <= length;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (issue) begin
            rom_addr_q  <= rom_addr_q + ADDR_ONE;
            remaining_q <= remaining_q - REM_ONE;
            if (remaining_q == REM_ONE) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (final_pop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Two-entry FIFO: captures ROM data for in-flight reads, pops on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (inflight_q) begin
        buf_data_q[wr_ptr_q] <= rom_data;
        buf_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({inflight_q, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign m_valid   = (count_q != 2'd0);
  assign m_data    = m_valid ? buf_data_q[rd_ptr_q] : '0;
  assign m_last    = m_valid & buf_last_q[rd_ptr_q];
  assign rom_addr  = rom_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_param_fetch_ctrl.sv
// Bench for param_fetch_ctrl: synchronous ROM model, directed and random
// bursts, checked against an expected-word queue built from the ROM contents.
module tb_param_fetch_ctrl;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [1:0]    dbg_state;

  param_fetch_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .dbg_state (dbg_state)
  );

  // Synchronous ROM: one-cycle read latency.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) rom_data <= mem[rom_addr];

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; the start pulse covers exactly one rising edge.
  task automatic do_start(input int b, input int l);
    start     = 1'b1;
    base_addr = AW'(b);
    length    = (AW+1)'(l);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams one burst that was started at the preceding rising edge.
  // mode: 0 ready always high, 1 fixed stall pattern, 2 random ready.
  task automatic stream(input int mode, input int b, input int l,
                        input bit chk_timing, input bit chk_addr,
                        input int stop_pops, input int poke_c,
                        input bit chain_en, input int chain_b, input int chain_l);
    int c;
    int pops;
    bit seen_valid;
    bit prev_stall;
    bit rdy;
    exp_q.delete();
    for (int k = 0; k < l; k++) exp_q.push_back(mem[(b + k) % DEPTH]);
    c = 0;
    pops = 0;
    seen_valid = 1'b0;
    prev_stall = 1'b0;
    forever begin
      if (c > 4 * l + 50) begin
        chk("timeout", 32'd1, 32'd0);
        return;
      end
      start = 1'b0;
      chk("fifo_le2", 32'(dut.count_q <= 2'd2), 32'd1);
      if (chk_addr && c < l) chk("rom_addr", 32'(rom_addr), 32'((b + c) % DEPTH));
      if (exp_q.size() == 0) begin
        chk("done", 32'(done), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        chk("valid_end", 32'(m_valid), 32'd0);
        if (chk_timing) chk("done_cycle", 32'(c), 32'(l + 2));
        if (chain_en) begin
          start     = 1'b1;
          base_addr = AW'(chain_b);
          length    = (AW+1)'(chain_l);
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'(chain_en));
        return;
      end
      chk("busy", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      if (prev_stall) chk("valid_held", 32'(m_valid), 32'd1);
      if (m_valid && !seen_valid) begin
        seen_valid = 1'b1;
        if (chk_timing) chk("first_valid", 32'(c), 32'd2);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[c % 7];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      m_ready = rdy;
      if (c == poke_c) begin
        start     = 1'b1;
        base_addr = AW'($urandom_range(0, DEPTH - 1));
        length    = (AW+1)'(5);
      end
      if (m_valid) begin
        chk("m_data", 32'(m_data), 32'(exp_q[0]));
        chk("m_last", 32'(m_last), 32'(exp_q.size() == 1));
        if (rdy) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
      prev_stall = m_valid && !rdy;
      @(negedge clk);
      c++;
      if (stop_pops > 0 && pops == stop_pops) return;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i - 128);
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    m_ready   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic burst, full throughput, timing checked.
    do_start(5, 4);
    stream(0, 5, 4, 1'b1, 1'b1, 0, -1, 1'b0, 0, 0);

    // Same burst under a fixed stall pattern.
    do_start(5, 4);
    stream(1, 5, 4, 1'b0, 1'b0, 0, -1, 1'b0, 0, 0);

    // Address wrap at the top of the ROM.
    do_start(1022, 4);
    stream(0, 1022, 4, 1'b1, 1'b1, 0, -1, 1'b0, 0, 0);

    // Zero-length request: lone done pulse, nothing streamed.
    do_start(7, 0);
    chk("zl_done", 32'(done), 32'd1);
    chk("zl_busy", 32'(busy), 32'd0);
    chk("zl_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("zl_done_pulse", 32'(done), 32'd0);
    chk("zl_valid2", 32'(m_valid), 32'd0);

    // start re-asserted mid-burst is ignored.
    do_start(40, 6);
    stream(1, 40, 6, 1'b0, 1'b0, 0, 3, 1'b0, 0, 0);

    // Reset after 2 of 8 beats aborts silently.
    do_start(200, 8);
    stream(0, 200, 8, 1'b0, 1'b0, 2, -1, 1'b0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_valid", 32'(m_valid), 32'd0);
    chk("ar_last", 32'(m_last), 32'd0);
    chk("ar_data", 32'(m_data), 32'd0);
    chk("ar_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(m_valid), 32'd0);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    do_start(0, 3);
    stream(0, 0, 3, 1'b1, 1'b1, 0, -1, 1'b0, 0, 0);

    // Back-to-back: second start in the done cycle.
    do_start(300, 3);
    stream(0, 300, 3, 1'b0, 1'b0, 0, -1, 1'b1, 100, 2);
    stream(0, 100, 2, 1'b0, 1'b0, 0, -1, 1'b0, 0, 0);

    // Random bursts with random backpressure.
    for (int r = 0; r < 6; r++) begin
      int rb;
      int rl;
      rb = int'($urandom_range(0, DEPTH - 1));
      rl = int'($urandom_range(1, 20));
      do_start(rb, rl);
      stream(2, rb, rl, 1'b0, 1'b0, 0, -1, 1'b0, 0, 0);
    end

    // Full-ROM burst with wrap.
    begin
      int fb;
      fb = int'($urandom_range(0, DEPTH - 1));
      do_start(fb, DEPTH);
      stream(2, fb, DEPTH, 1'b0, 1'b0, 0, -1, 1'b0, 0, 0);
    end

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
